// File: rtl/load_align_unit_if.sv
// Load-path bundle: request channel, aligned memory read channel, response channel.
interface load_align_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              reqValid;
  logic              reqReady;
  logic [ADDR_W-1:0] reqAddr;
  logic [2:0]        reqCtrl;
  logic              memReqValid;
  logic              memReqReady;
  logic [ADDR_W-1:0] memAddr;
  logic              memRspValid;
  logic [XLEN-1:0]   memRspData;
  logic              rspValid;
  logic              rspReady;
  logic [XLEN-1:0]   rspData;
  logic              rspFault;

  modport slave (
    input  reqValid, reqAddr, reqCtrl, memReqReady, memRspValid, memRspData, rspReady,
    output reqReady, memReqValid, memAddr, rspValid, rspData, rspFault
  );

  modport master (
    output reqValid, reqAddr, reqCtrl, memReqReady, memRspValid, memRspData, rspReady,
    input  reqReady, memReqValid, memAddr, rspValid, rspData, rspFault
  );
endinterface

// File: rtl/load_align_unit.sv
// Load align unit: issues aligned reads, merges, extracts and extends load data.
// LOAD_MISALIGN_EN: when defined, misaligned loads are split into two reads; otherwise they fault.
module load_align_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rstn,
  load_align_unit_if.slave   bus
);
  localparam int B     = XLEN / 8;
  localparam int OFF_W = $clog2(B);

  typedef enum logic [2:0] {IDLE, RD0, WAIT0, RD1, WAIT1, RESP} state_e;

  state_e            state_q;
  logic              reqReady_q, memReqValid_q, rspValid_q, rspFault_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [XLEN-1:0]   rspData_q;
  logic [OFF_W-1:0]  off_q;
  logic [2:0]        ctrl_q;
`ifdef LOAD_MISALIGN_EN
  logic [XLEN-1:0]   word0_q;
  logic              split_q;
`endif

  assign bus.reqReady    = reqReady_q;
  assign bus.memReqValid = memReqValid_q;
  assign bus.memAddr     = memAddr_q;
  assign bus.rspValid    = rspValid_q;
  assign bus.rspData     = rspData_q;
  assign bus.rspFault    = rspFault_q;

  // Request decode; only feeds registers on accept.
  logic [OFF_W-1:0]  req_off;
  logic [4:0]        req_size;
  logic              req_illegal, req_misal, wait0_split;
  always_comb begin
    req_off     = bus.reqAddr[OFF_W-1:0];
    req_size    = 5'd1 << bus.reqCtrl[1:0];
    req_illegal = (bus.reqCtrl == 3'b111) ||
                  ((XLEN == 32) && (bus.reqCtrl == 3'b011 || bus.reqCtrl == 3'b110));
    req_misal   = (5'(req_off) + req_size) > 5'(B);
`ifdef LOAD_MISALIGN_EN
    wait0_split = split_q;
`else
    wait0_split = 1'b0;
`endif
  end

  // Merge the word pair, shift the addressed bytes down, then extend.
  logic [XLEN-1:0]   w_lo, w_hi, raw, ext_data;
  logic [OFF_W+2:0]  sh;
  always_comb begin
`ifdef LOAD_MISALIGN_EN
    w_lo = (state_q == WAIT1) ? word0_q : bus.memRspData;
    w_hi = (state_q == WAIT1) ? bus.memRspData : '0;
`else
    w_lo = bus.memRspData;
    w_hi = '0;
`endif
    sh  = {off_q, 3'b000};
    raw = XLEN'({w_hi, w_lo} >> sh);
    case (ctrl_q[1:0])
      2'd0:    ext_data = ctrl_q[2] ? XLEN'(raw[7:0])  : XLEN'($signed(raw[7:0]));
      2'd1:    ext_data = ctrl_q[2] ? XLEN'(raw[15:0]) : XLEN'($signed(raw[15:0]));
      2'd2:    ext_data = ctrl_q[2] ? XLEN'(raw[31:0]) : XLEN'($signed(raw[31:0]));
      default: ext_data = raw;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      reqReady_q    <= 1'b0;
      memReqValid_q <= 1'b0;
      memAddr_q     <= '0;
      rspValid_q    <= 1'b0;
      rspData_q     <= '0;
      rspFault_q    <= 1'b0;
      off_q         <= '0;
      ctrl_q        <= '0;
`ifdef LOAD_MISALIGN_EN
      word0_q       <= '0;
      split_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          reqReady_q <= 1'b1;
          if (bus.reqValid && reqReady_q) begin
            reqReady_q <= 1'b0;
            off_q      <= req_off;
            ctrl_q     <= bus.reqCtrl;
`ifdef LOAD_MISALIGN_EN
            split_q    <= req_misal;
            if (req_illegal) begin
`else
            if (req_illegal || req_misal) begin
`endif
              state_q    <= RESP;
              rspValid_q <= 1'b1;
              rspFault_q <= 1'b1;
              rspData_q  <= '0;
            end else begin
              state_q       <= RD0;
              memReqValid_q <= 1'b1;
              memAddr_q     <= {bus.reqAddr[ADDR_W-1:OFF_W], OFF_W'(0)};
            end
          end
        end
        RD0: if (bus.memReqReady) begin
          memReqValid_q <= 1'b0;
          state_q       <= WAIT0;
        end
        WAIT0: if (bus.memRspValid) begin
          if (wait0_split) begin
`ifdef LOAD_MISALIGN_EN
            word0_q       <= bus.memRspData;
            memReqValid_q <= 1'b1;
            memAddr_q     <= memAddr_q + ADDR_W'(B);  // wraps modulo address space
            state_q       <= RD1;
`endif
          end else begin
            rspValid_q <= 1'b1;
            rspFault_q <= 1'b0;
            rspData_q  <= ext_data;
            state_q    <= RESP;
          end
        end
`ifdef LOAD_MISALIGN_EN
        RD1: if (bus.memReqReady) begin
          memReqValid_q <= 1'b0;
          state_q       <= WAIT1;
        end
        WAIT1: if (bus.memRspValid) begin
          rspValid_q <= 1'b1;
          rspFault_q <= 1'b0;
          rspData_q  <= ext_data;
          state_q    <= RESP;
        end
`endif
        RESP: if (bus.rspReady) begin
          rspValid_q <= 1'b0;
          rspFault_q <= 1'b0;
          rspData_q  <= '0;
          reqReady_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: XLEN=32 and XLEN=64 instances, hand-computed vectors.
module tb_load_align_unit;
  logic clk, rstn;
  int   n_chk, n_pass;

  load_align_unit_if #(.XLEN(32), .ADDR_W(32)) b32 ();
  load_align_unit_if #(.XLEN(64), .ADDR_W(32)) b64 ();

  load_align_unit #(.XLEN(32), .ADDR_W(32)) u32 (.clk(clk), .rstn(rstn), .bus(b32.slave));
  load_align_unit #(.XLEN(64), .ADDR_W(32)) u64 (.clk(clk), .rstn(rstn), .bus(b64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic run32(input string tag, input logic [31:0] addr, input logic [2:0] ctrl,
                       input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] exp_d,
                       input logic exp_f, input int exp_lat, input int exp_nrd,
                       input logic [31:0] ea0, input logic [31:0] ea1,
                       input int rq_stall, input int rs_stall);
    int cyc, nrd, stall;
    logic pend, done;
    logic [31:0] pdata;
    logic [31:0] ra [2];
    nrd = 0; pend = 0; done = 0; stall = rq_stall; pdata = '0; ra[0] = '0; ra[1] = '0;
    chk({tag, ".rdy"}, 64'(b32.reqReady), 64'd1);
    b32.reqValid = 1'b1; b32.reqAddr = addr; b32.reqCtrl = ctrl;
    @(posedge clk); #1;
    b32.reqValid = 1'b0; cyc = 1;
    chk({tag, ".busy"}, 64'(b32.reqReady), 64'd0);
    while (!done && cyc < 40) begin
      b32.memRspValid = pend;
      b32.memRspData  = pend ? pdata : '0;
      pend = 1'b0;
      b32.memReqReady = 1'b0;
      if (b32.rspValid) done = 1'b1;
      else begin
        if (b32.memReqValid) begin
          if (stall > 0) begin
            chk({tag, ".addr_hold"}, 64'(b32.memAddr), 64'(nrd == 0 ? ea0 : ea1));
            stall--;
          end else begin
            b32.memReqReady = 1'b1;
            if (nrd < 2) ra[nrd] = b32.memAddr;
            pdata = (nrd == 0) ? w0 : w1;
            pend  = 1'b1;
            nrd++;
          end
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    b32.memRspValid = 1'b0;
    chk({tag, ".lat"},   64'(cyc), 64'(exp_lat));
    chk({tag, ".nrd"},   64'(nrd), 64'(exp_nrd));
    chk({tag, ".data"},  64'(b32.rspData), 64'(exp_d));
    chk({tag, ".fault"}, 64'(b32.rspFault), 64'(exp_f));
    if (exp_nrd > 0) chk({tag, ".a0"}, 64'(ra[0]), 64'(ea0));
    if (exp_nrd > 1) chk({tag, ".a1"}, 64'(ra[1]), 64'(ea1));
    for (int i = 0; i < rs_stall; i++) begin
      @(posedge clk); #1;
      chk({tag, ".data_hold"}, 64'(b32.rspData), 64'(exp_d));
      chk({tag, ".vld_hold"},  64'(b32.rspValid), 64'd1);
    end
    b32.rspReady = 1'b1;
    @(posedge clk); #1;
    b32.rspReady = 1'b0;
    chk({tag, ".vld_drop"}, 64'(b32.rspValid), 64'd0);
  endtask

  task automatic run64(input string tag, input logic [31:0] addr, input logic [2:0] ctrl,
                       input logic [63:0] w0, input logic [63:0] exp_d, input logic exp_f,
                       input int exp_lat, input int exp_nrd, input logic [31:0] ea0);
    int cyc, nrd;
    logic pend, done;
    logic [31:0] ra;
    nrd = 0; pend = 0; done = 0; ra = '0;
    chk({tag, ".rdy"}, 64'(b64.reqReady), 64'd1);
    b64.reqValid = 1'b1; b64.reqAddr = addr; b64.reqCtrl = ctrl;
    @(posedge clk); #1;
    b64.reqValid = 1'b0; cyc = 1;
    while (!done && cyc < 40) begin
      b64.memRspValid = pend;
      b64.memRspData  = pend ? w0 : '0;
      pend = 1'b0;
      b64.memReqReady = 1'b0;
      if (b64.rspValid) done = 1'b1;
      else begin
        if (b64.memReqValid) begin
          b64.memReqReady = 1'b1;
          ra = b64.memAddr; pend = 1'b1; nrd++;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    b64.memRspValid = 1'b0;
    chk({tag, ".lat"},   64'(cyc), 64'(exp_lat));
    chk({tag, ".nrd"},   64'(nrd), 64'(exp_nrd));
    chk({tag, ".data"},  b64.rspData, exp_d);
    chk({tag, ".fault"}, 64'(b64.rspFault), 64'(exp_f));
    if (exp_nrd > 0) chk({tag, ".a0"}, 64'(ra), 64'(ea0));
    b64.rspReady = 1'b1;
    @(posedge clk); #1;
    b64.rspReady = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0;
    rstn = 1'b0;
    b32.reqValid = 0; b32.reqAddr = '0; b32.reqCtrl = '0; b32.memReqReady = 0;
    b32.memRspValid = 0; b32.memRspData = '0; b32.rspReady = 0;
    b64.reqValid = 0; b64.reqAddr = '0; b64.reqCtrl = '0; b64.memReqReady = 0;
    b64.memRspValid = 0; b64.memRspData = '0; b64.rspReady = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rdy",   64'(b32.reqReady), 64'd0);
    chk("rst.mrv",   64'(b32.memReqValid), 64'd0);
    chk("rst.maddr", 64'(b32.memAddr), 64'd0);
    chk("rst.rv",    64'(b32.rspValid), 64'd0);
    chk("rst.rd",    64'(b32.rspData), 64'd0);
    chk("rst.rf",    64'(b32.rspFault), 64'd0);
    chk("rst64.rdy", 64'(b64.reqReady), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run32("lb",   32'h103, 3'b000, 32'h80FF_0000, '0, 32'hFFFF_FF80, 0, 3, 1, 32'h100, '0, 0, 0);
    run32("lhu",  32'h102, 3'b101, 32'hBEEF_1234, '0, 32'h0000_BEEF, 0, 3, 1, 32'h100, '0, 0, 0);
    run32("lh",   32'h002, 3'b001, 32'h8001_0000, '0, 32'hFFFF_8001, 0, 3, 1, 32'h000, '0, 0, 0);
    run32("lbu",  32'h101, 3'b100, 32'h0000_F000, '0, 32'h0000_00F0, 0, 3, 1, 32'h100, '0, 0, 0);
    run32("lw0",  32'h000, 3'b010, 32'h89AB_CDEF, '0, 32'h89AB_CDEF, 0, 3, 1, 32'h000, '0, 0, 0);
`ifdef LOAD_MISALIGN_EN
    run32("lwmis", 32'h203, 3'b010, 32'h4433_2211, 32'h8877_6655, 32'h7766_5544, 0, 5, 2,
          32'h200, 32'h204, 0, 0);
    run32("lhmis", 32'h003, 3'b001, 32'hAA00_0000, 32'h0000_00BB, 32'hFFFF_BBAA, 0, 5, 2,
          32'h000, 32'h004, 0, 0);
    run32("lwrap", 32'hFFFF_FFFE, 3'b010, 32'hBBAA_0000, 32'h0000_DDCC, 32'hDDCC_BBAA, 0, 5, 2,
          32'hFFFF_FFFC, 32'h0, 0, 0);
`else
    run32("lwmis", 32'h203, 3'b010, 32'h4433_2211, 32'h8877_6655, '0, 1, 1, 0, '0, '0, 0, 0);
    run32("lhmis", 32'h003, 3'b001, 32'hAA00_0000, 32'h0000_00BB, '0, 1, 1, 0, '0, '0, 0, 0);
    run32("lwrap", 32'hFFFF_FFFE, 3'b010, 32'hBBAA_0000, 32'h0000_DDCC, '0, 1, 1, 0, '0, '0, 0, 0);
`endif
    run32("ld32",  32'h100, 3'b011, 32'h1111_1111, '0, '0, 1, 1, 0, '0, '0, 0, 0);
    run32("lwu32", 32'h100, 3'b110, 32'h1111_1111, '0, '0, 1, 1, 0, '0, '0, 0, 0);
    run32("ill",   32'h100, 3'b111, 32'h1111_1111, '0, '0, 1, 1, 0, '0, '0, 0, 0);
    run32("bp",    32'h300, 3'b010, 32'h1234_5678, '0, 32'h1234_5678, 0, 8, 1, 32'h300, '0, 5, 3);

    // Abandon a load in WAIT0 via reset; its late response must be ignored.
    b32.reqValid = 1'b1; b32.reqAddr = 32'h400; b32.reqCtrl = 3'b010;
    @(posedge clk); #1;
    b32.reqValid = 1'b0; b32.memReqReady = 1'b1;
    @(posedge clk); #1;
    b32.memReqReady = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid.rdy",   64'(b32.reqReady), 64'd0);
    chk("mid.mrv",   64'(b32.memReqValid), 64'd0);
    chk("mid.maddr", 64'(b32.memAddr), 64'd0);
    chk("mid.rv",    64'(b32.rspValid), 64'd0);
    chk("mid.rd",    64'(b32.rspData), 64'd0);
    chk("mid.rf",    64'(b32.rspFault), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    b32.memRspValid = 1'b1; b32.memRspData = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    b32.memRspValid = 1'b0; b32.memRspData = '0;
    chk("late.rv", 64'(b32.rspValid), 64'd0);
    run32("post", 32'h401, 3'b100, 32'h0000_5A00, '0, 32'h0000_005A, 0, 3, 1, 32'h400, '0, 0, 0);

    run64("lwu64", 32'h4, 3'b110, 64'h8000_0000_1234_5678, 64'h0000_0000_8000_0000, 0, 3, 1, 32'h0);
    run64("lw64",  32'h4, 3'b010, 64'h8000_0000_1234_5678, 64'hFFFF_FFFF_8000_0000, 0, 3, 1, 32'h0);
    run64("ld64",  32'h8, 3'b011, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0, 3, 1, 32'h8);
    run64("lb64",  32'hF, 3'b000, 64'h7F00_0000_0000_0000, 64'h0000_0000_0000_007F, 0, 3, 1, 32'h8);
    run64("ill64", 32'h8, 3'b111, 64'h0, 64'h0, 1, 1, 0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
